// File: rtl/if_prefetch_stage.sv
// ---------------------------------------------------------------------------
// if_prefetch_stage
//
// Pipelined instruction-fetch front end. It issues requests on a req/gnt/
// rvalid instruction-memory interface with up to MAX_OUTSTANDING granted
// requests in flight. Returned words are stored with their PC in a
// FIFO_DEPTH-entry prefetch buffer, and the head entry is offered to ID
// through a valid/ready handshake. A branch flushes the buffer and drops
// every response still in flight for the old stream.
//
// Optional feature macro: IF_STALL_CNT_EN
//    When defined, adds stall_count_o. This is a saturating 32-bit count of
//    the cycles in which fetch_en_i=1 and instr_valid_o=0.
//
// Ports
//    clk, rst             clock, synchronous active-high reset
//    instr_req_o          memory request, held with a stable address until gnt
//    instr_addr_o         word-aligned request address
//    instr_gnt_i          request accepted this cycle
//    instr_rvalid_i       in-order response valid
//    instr_rdata_i        response data
//    fetch_en_i           allow new requests
//    pc_start_address_i   fetch address loaded during reset
//    branch_pc_ctrl_i     one-cycle redirect strobe
//    pc_branch_addr_i     redirect target (low two bits ignored)
//    instr_valid_o        head entry valid
//    instr_ready_i        ID accepts the head entry
//    instruction_o        head instruction
//    program_count_o      PC of the head instruction
//    no_op_flag_o         !instr_valid_o
//    stall_count_o        (IF_STALL_CNT_EN only) fetch stall cycle count
//
// FSM states
//    state            | meaning
//    S_RESET          | reset asserted, nothing issued
//    S_IDLE           | fetch disabled, no request pending on the bus
//    S_FETCH          | requests issued while buffer/outstanding room allows
//    S_WAIT_GNT_BRANCH| branch taken behind an ungranted request; target parked
// ---------------------------------------------------------------------------
module if_prefetch_stage #(
   parameter int WORD_WIDTH      = 32,
   parameter int FIFO_DEPTH      = 4,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  instr_req_o,
   output logic [WORD_WIDTH-1:0] instr_addr_o,
   input  logic                  instr_gnt_i,
   input  logic                  instr_rvalid_i,
   input  logic [WORD_WIDTH-1:0] instr_rdata_i,
   input  logic                  fetch_en_i,
   input  logic [WORD_WIDTH-1:0] pc_start_address_i,
   input  logic                  branch_pc_ctrl_i,
   input  logic [WORD_WIDTH-1:0] pc_branch_addr_i,
   output logic                  instr_valid_o,
   input  logic                  instr_ready_i,
   output logic [WORD_WIDTH-1:0] instruction_o,
   output logic [WORD_WIDTH-1:0] program_count_o,
   output logic                  no_op_flag_o
`ifdef IF_STALL_CNT_EN
   ,
   output logic [31:0]           stall_count_o
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {
      S_RESET,
      S_IDLE,
      S_FETCH,
      S_WAIT_GNT_BRANCH
   } state_t;

   state_t state_q, state_d;

   logic [WORD_WIDTH-1:0] fetch_addr_q;
   logic [WORD_WIDTH-1:0] resp_pc_q;
   logic [WORD_WIDTH-1:0] pend_addr_q;
   logic                  req_hold_q;
   logic [OUT_W-1:0]      out_q;
   logic [OUT_W-1:0]      discard_q;
   logic [CNT_W-1:0]      count_q;
   logic [PTR_W-1:0]      rd_ptr_q;
   logic [PTR_W-1:0]      wr_ptr_q;

   logic [WORD_WIDTH-1:0] buf_data [FIFO_DEPTH];
   logic [WORD_WIDTH-1:0] buf_pc   [FIFO_DEPTH];

   logic [WORD_WIDTH-1:0] start_aligned;
   logic [WORD_WIDTH-1:0] branch_tgt;
   logic                  room;
   logic                  req;
   logic                  granted;
   logic                  branch_defer;
   logic                  drop;
   logic                  push;
   logic                  pop;
   logic                  valid;
   logic                  branch_pending;

   // Masking keeps every input bit in use while forcing word alignment.
   assign start_aligned = pc_start_address_i & ~WORD_WIDTH'(3);
   assign branch_tgt    = pc_branch_addr_i & ~WORD_WIDTH'(3);

   // Room is judged on registered counts: every request in flight already
   // has a reserved buffer slot, so a push can never hit a full buffer.
   assign room = (32'(out_q) < 32'(MAX_OUTSTANDING)) &&
                 ((32'(count_q) + 32'(out_q)) < 32'(FIFO_DEPTH));

   // An ungranted request stays up regardless of fetch_en_i or branch.
   assign req          = !rst && (req_hold_q || (fetch_en_i && room));
   assign granted      = req && instr_gnt_i;
   assign branch_defer = branch_pc_ctrl_i && req && !instr_gnt_i;

   assign drop  = instr_rvalid_i && (discard_q != '0);
   assign push  = !rst && instr_rvalid_i && (discard_q == '0) && !branch_pc_ctrl_i;
   assign valid = !rst && (count_q != '0);
   assign pop   = valid && instr_ready_i && !branch_pc_ctrl_i;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_RESET;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET:
            state_d = branch_defer ? S_WAIT_GNT_BRANCH : S_IDLE;
         S_IDLE:
            if (branch_defer)    state_d = S_WAIT_GNT_BRANCH;
            else if (fetch_en_i) state_d = S_FETCH;
         S_FETCH:
            if (branch_defer)                             state_d = S_WAIT_GNT_BRANCH;
            else if (!fetch_en_i && !(req && !instr_gnt_i)) state_d = S_IDLE;
         S_WAIT_GNT_BRANCH:
            if (instr_gnt_i) state_d = fetch_en_i ? S_FETCH : S_IDLE;
         default:
            state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      branch_pending = (state_q == S_WAIT_GNT_BRANCH);
   end

   // ---------------- request / response bookkeeping ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_addr_q <= start_aligned;
         resp_pc_q    <= start_aligned;
         pend_addr_q  <= '0;
         req_hold_q   <= 1'b0;
         out_q        <= '0;
         discard_q    <= '0;
         count_q      <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
      end else begin
         req_hold_q <= req && !instr_gnt_i;
         out_q      <= out_q + OUT_W'(granted) - OUT_W'(instr_rvalid_i);

         // A branch with no stalled request redirects at once; otherwise the
         // target waits in pend_addr_q and is applied on the grant cycle.
         if (branch_pc_ctrl_i && !branch_defer)
            fetch_addr_q <= branch_tgt;
         else if (granted && branch_pending)
            fetch_addr_q <= pend_addr_q;
         else if (granted)
            fetch_addr_q <= fetch_addr_q + WORD_WIDTH'(4);

         if (branch_defer)
            pend_addr_q <= branch_tgt;

         // Everything in flight at the branch (including a request granted
         // in the same cycle) is stale. A parked branch adds the old request
         // when it is finally granted.
         if (branch_pc_ctrl_i)
            discard_q <= out_q - OUT_W'(instr_rvalid_i) + OUT_W'(granted);
         else
            discard_q <= discard_q - OUT_W'(drop) + OUT_W'(granted && branch_pending);

         if (branch_pc_ctrl_i)
            resp_pc_q <= branch_tgt;
         else if (push)
            resp_pc_q <= resp_pc_q + WORD_WIDTH'(4);

         if (branch_pc_ctrl_i) begin
            count_q  <= '0;
            rd_ptr_q <= wr_ptr_q;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
         end

         assert (!(push && (count_q == CNT_W'(FIFO_DEPTH))));
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_data[wr_ptr_q] <= instr_rdata_i;
         buf_pc[wr_ptr_q]   <= resp_pc_q;
      end
   end

`ifdef IF_STALL_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst)
         stall_q <= '0;
      else if (fetch_en_i && !valid && (stall_q != 32'hFFFF_FFFF))
         stall_q <= stall_q + 32'd1;
   end

   assign stall_count_o = stall_q;
`endif

   assign instr_req_o     = req;
   assign instr_addr_o    = fetch_addr_q;
   assign instr_valid_o   = valid;
   assign instruction_o   = buf_data[rd_ptr_q];
   assign program_count_o = buf_pc[rd_ptr_q];
   assign no_op_flag_o    = !valid;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// ---------------------------------------------------------------------------
// Testbench for if_prefetch_stage. The bench plays the instruction memory.
// Each granted address is queued and answered in order after `lat` cycles.
// The answer is memf(addr), so every word identifies the address it came
// from.
//
// The reference model sits at the stream level. ID must see consecutive PCs
// starting at the reset address or at the latest aligned branch target, and
// each word must equal memf(pc). A stale word therefore fails either on its
// PC or on its data.
// ---------------------------------------------------------------------------
module tb_if_prefetch_stage;

   localparam int W    = 32;
   localparam int DEPTH = 4;
   localparam int MAXO  = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          req;
   logic [W-1:0]  addr;
   logic          gnt;
   logic          rvalid;
   logic [W-1:0]  rdata;
   logic          fetch_en;
   logic [W-1:0]  start_addr;
   logic          branch;
   logic [W-1:0]  branch_addr;
   logic          valid;
   logic          ready;
   logic [W-1:0]  instr;
   logic [W-1:0]  pc;
   logic          no_op;
`ifdef IF_STALL_CNT_EN
   logic [31:0]   stall_count;
`endif

   always #5 clk = ~clk;

   if_prefetch_stage #(
      .WORD_WIDTH     (W),
      .FIFO_DEPTH     (DEPTH),
      .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .instr_req_o       (req),
      .instr_addr_o      (addr),
      .instr_gnt_i       (gnt),
      .instr_rvalid_i    (rvalid),
      .instr_rdata_i     (rdata),
      .fetch_en_i        (fetch_en),
      .pc_start_address_i(start_addr),
      .branch_pc_ctrl_i  (branch),
      .pc_branch_addr_i  (branch_addr),
      .instr_valid_o     (valid),
      .instr_ready_i     (ready),
      .instruction_o     (instr),
      .program_count_o   (pc),
      .no_op_flag_o      (no_op)
`ifdef IF_STALL_CNT_EN
      ,
      .stall_count_o     (stall_count)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;

   int            cyc;
   int            lat;
   logic [W-1:0]  mq_addr[$];
   int            mq_due[$];
   logic [W-1:0]  gl[$];
   int            gcyc[$];
   logic [W-1:0]  pl[$];
   int            first_valid;
   logic [W-1:0]  first_pc;
   logic          last_req;
   logic          last_valid;
   logic          prev_pend;
   logic          prev_branch;
   logic [W-1:0]  prev_addr;
   logic [W-1:0]  exp_pc;

   function automatic logic [W-1:0] memf(input logic [W-1:0] a);
      return (a ^ 32'hC0DE_0000) + 32'h0000_0013;
   endfunction

   function automatic logic [W-1:0] qget(input logic [W-1:0] q[$], input int i);
      if (q.size() > i) return q[i];
      return 32'hDEAD_BEEF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One cycle: drive the memory response, sample #1 later, compare with the
   // model, record handshakes that happen at the coming edge, then advance.
   task step;
      if (!rst && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
         rvalid = 1'b1;
         rdata  = memf(mq_addr[0]);
         mq_addr.delete(0);
         mq_due.delete(0);
      end else begin
         rvalid = 1'b0;
         rdata  = '0;
      end
      #1;
      chk("no_op", 32'(no_op), 32'(!valid));
      if (rst) begin
         chk("rst_req", 32'(req), 32'd0);
         chk("rst_valid", 32'(valid), 32'd0);
      end else begin
         if (prev_pend) begin
            chk("req_hold", 32'(req), 32'd1);
            chk("addr_hold", addr, prev_addr);
         end
         if (prev_branch) chk("flush", 32'(valid), 32'd0);
         if (valid && first_valid < 0) begin
            first_valid = cyc;
            first_pc    = pc;
         end
         if (valid && ready && !branch) begin
            chk("pop_pc", pc, exp_pc);
            chk("pop_data", instr, memf(exp_pc));
            pl.push_back(pc);
            exp_pc = exp_pc + 32'd4;
         end
         if (branch) exp_pc = branch_addr & ~32'h3;
         if (req && gnt) begin
            mq_addr.push_back(addr);
            mq_due.push_back(cyc + lat);
            gl.push_back(addr);
            gcyc.push_back(cyc);
         end
         chk("outstanding_bound", 32'(mq_addr.size() <= MAXO), 32'd1);
      end
      prev_pend   = !rst && req && !gnt;
      prev_addr   = addr;
      prev_branch = !rst && branch;
      last_req    = req;
      last_valid  = valid;
      if (rst) begin
         mq_addr.delete();
         mq_due.delete();
         exp_pc = start_addr & ~32'h3;
      end
      @(negedge clk);
      cyc++;
   endtask

   task do_reset(input logic [W-1:0] s);
      start_addr = s;
      branch     = 1'b0;
      rst        = 1'b1;
      step;
      step;
      rst         = 1'b0;
      cyc         = 0;
      gl.delete();
      gcyc.delete();
      pl.delete();
      first_valid = -1;
      first_pc    = '0;
      prev_pend   = 1'b0;
      prev_branch = 1'b0;
   endtask

   initial begin
      rst = 1'b1; fetch_en = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
      branch = 1'b0; branch_addr = '0; ready = 1'b0; start_addr = '0;
      lat = 1; cyc = 0; first_valid = -1; first_pc = '0;
      prev_pend = 1'b0; prev_branch = 1'b0; prev_addr = '0; exp_pc = '0;
      last_req = 1'b0; last_valid = 1'b0;
      @(negedge clk);

      // S1: streaming, one grant per cycle, rvalid one cycle after gnt
      fetch_en = 1'b1; gnt = 1'b1; ready = 1'b1; lat = 1;
      do_reset(32'h100);
      repeat (12) step;
      chk("s1_addr0", qget(gl, 0), 32'h100);
      chk("s1_addr1", qget(gl, 1), 32'h104);
      chk("s1_addr2", qget(gl, 2), 32'h108);
      chk("s1_gcyc0", 32'((gcyc.size() > 0) ? gcyc[0] : -1), 32'd0);
      chk("s1_gcyc2", 32'((gcyc.size() > 2) ? gcyc[2] : -1), 32'd2);
      chk("s1_first_valid_cyc", 32'(first_valid), 32'd2);
      chk("s1_first_pc", first_pc, 32'h100);
      chk("s1_pops", 32'(pl.size()), 32'd10);

      // S2: ID stalled -> exactly DEPTH words fetched, then drained in order
      ready = 1'b0;
      do_reset(32'h100);
      repeat (10) step;
      chk("s2_grants", 32'(gl.size()), 32'd4);
      chk("s2_req_dropped", 32'(last_req), 32'd0);
      chk("s2_valid_full", 32'(last_valid), 32'd1);
      fetch_en = 1'b0; ready = 1'b1;
      pl.delete();
      repeat (6) step;
      chk("s2_drain_pops", 32'(pl.size()), 32'd4);
      chk("s2_drain_pc0", qget(pl, 0), 32'h100);
      chk("s2_drain_pc3", qget(pl, 3), 32'h10C);
      chk("s2_empty", 32'(last_valid), 32'd0);
      chk("s2_idle_req", 32'(last_req), 32'd0);

      // S3: branch with two requests outstanding
      fetch_en = 1'b1; ready = 1'b1; gnt = 1'b1; lat = 3;
      do_reset(32'h100);
      repeat (2) step;
      chk("s3_inflight", 32'(mq_addr.size()), 32'd2);
      branch = 1'b1; branch_addr = 32'h2002;
      step;
      branch = 1'b0;
      repeat (12) step;
      chk("s3_new_addr", qget(gl, 2), 32'h2000);
      chk("s3_first_pop", qget(pl, 0), 32'h2000);
      chk("s3_first_pc", first_pc, 32'h2000);

      // S4: branch while the request waits 3 cycles for gnt
      lat = 1; gnt = 1'b0;
      do_reset(32'h100);
      branch = 1'b1; branch_addr = 32'h3000;
      step;
      branch = 1'b0;
      step;
      step;
      gnt = 1'b1;
      repeat (10) step;
      chk("s4_old_addr", qget(gl, 0), 32'h100);
      chk("s4_old_gcyc", 32'((gcyc.size() > 0) ? gcyc[0] : -1), 32'd3);
      chk("s4_target_addr", qget(gl, 1), 32'h3000);
      chk("s4_first_pop", qget(pl, 0), 32'h3000);

      // S4b: second branch overwrites the parked target
      gnt = 1'b0;
      do_reset(32'h100);
      branch = 1'b1; branch_addr = 32'h3000;
      step;
      branch_addr = 32'h4006;
      step;
      branch = 1'b0;
      step;
      gnt = 1'b1;
      repeat (10) step;
      chk("s4b_target_addr", qget(gl, 1), 32'h4004);
      chk("s4b_first_pop", qget(pl, 0), 32'h4004);

      // S5: address wrap
      gnt = 1'b1; lat = 1;
      do_reset(32'hFFFF_FFF8);
      repeat (8) step;
      chk("s5_addr0", qget(gl, 0), 32'hFFFF_FFF8);
      chk("s5_addr1", qget(gl, 1), 32'hFFFF_FFFC);
      chk("s5_addr2", qget(gl, 2), 32'h0000_0000);
      chk("s5_pop2", qget(pl, 2), 32'h0000_0000);

`ifdef IF_STALL_CNT_EN
      // S6: stall counter with no grants
      fetch_en = 1'b1; gnt = 1'b0;
      do_reset(32'h100);
      repeat (10) step;
      chk("s6_stall_count", stall_count, 32'd10);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
